// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared constants and state encoding for the uart_tx front-end arbiter
package uart_pkg;

    localparam int N_REQ_MAX = 8;
    localparam int BYTE_W    = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'b001,
        ST_ISSUE = 3'b010,
        ST_WAIT  = 3'b100
    } arb_state_e;

endpackage

// File: rtl/uart_tx_arb_rr_pick.sv
// rtl/uart_tx_arb_rr_pick.sv - combinational round-robin pick: rotate, priority select, un-rotate
module rr_pick #(
    parameter int N     = 4,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     i_req,
    input  logic [IDX_W-1:0] i_last,
    output logic             o_found,
    output logic [N-1:0]     o_onehot,
    output logic [IDX_W-1:0] o_idx
);

    logic [N-1:0]     rot;
    logic [IDX_W-1:0] pos;

    // rot[0] is the requester just after the previous winner
    always_comb begin
        rot = '0;
        for (int i = 0; i < N; i++) begin
            rot[i] = i_req[(int'(i_last) + 1 + i) % N];
        end
    end

    always_comb begin
        o_found = 1'b0;
        pos     = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) begin
                o_found = 1'b1;
                pos     = IDX_W'(i);
            end
        end
        o_idx    = IDX_W'((int'(i_last) + 1 + int'(pos)) % N);
        o_onehot = N'(o_found) << o_idx;
    end

endmodule

// File: rtl/uart_tx_arb.sv
// rtl/uart_tx_arb.sv - round-robin byte arbiter feeding one uart_tx serializer
// Optional packet lock: define UART_TX_ARB_PACKET_LOCK_EN.
module uart_tx_arb
    import uart_pkg::*;
#(
    parameter int N_REQ = 4
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic [N_REQ-1:0]        i_req_valid,
    input  logic [BYTE_W*N_REQ-1:0] i_req_byte,
    input  logic [N_REQ-1:0]        i_req_last,
    output logic [N_REQ-1:0]        o_req_ready,
    output logic [N_REQ-1:0]        o_grant,
    output logic                    o_tx_byte_rdy,
    output logic [BYTE_W-1:0]       o_tx_byte,
    input  logic                    i_tx_busy,
    input  logic                    i_tx_done,
    output logic                    o_busy
);

    localparam int IDX_W = $clog2(N_REQ);

    if (N_REQ < 2 || N_REQ > N_REQ_MAX) begin : g_bad_n_req
        $error("uart_tx_arb: N_REQ out of range");
    end

    arb_state_e        state_q, state_d;
    logic [IDX_W-1:0]  last_q, last_d;
    logic [N_REQ-1:0]  grant_q, grant_d;
    logic [BYTE_W-1:0] byte_q, byte_d;

    logic [N_REQ-1:0]  eligible;
    logic              pick_found;
    logic [N_REQ-1:0]  pick_onehot;
    logic [IDX_W-1:0]  pick_idx;
    logic              capture;

`ifdef UART_TX_ARB_PACKET_LOCK_EN
    logic lock_q, lock_d;

    // while locked the owner is always the previous winner held in last_q
    assign eligible = lock_q ? (i_req_valid & (N_REQ'(1) << last_q)) : i_req_valid;

    always_comb begin
        lock_d = lock_q;
        if (capture) begin
            lock_d = !i_req_last[pick_idx];
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            lock_q <= 1'b0;
        end else begin
            lock_q <= lock_d;
        end
    end
`else
    logic unused_req_last;

    assign unused_req_last = ^i_req_last;
    assign eligible        = i_req_valid;
`endif

    rr_pick #(
        .N     (N_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .i_req    (eligible),
        .i_last   (last_q),
        .o_found  (pick_found),
        .o_onehot (pick_onehot),
        .o_idx    (pick_idx)
    );

    assign capture = (state_q == ST_IDLE) && pick_found && !i_tx_busy;

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        grant_d = grant_q;
        byte_d  = byte_q;
        unique case (state_q)
            ST_IDLE: begin
                if (capture) begin
                    state_d = ST_ISSUE;
                    last_d  = pick_idx;
                    grant_d = pick_onehot;
                    byte_d  = i_req_byte[pick_idx*BYTE_W +: BYTE_W];
                end
            end
            ST_ISSUE: state_d = ST_WAIT;
            // done is only meaningful once the frame has been started
            ST_WAIT: begin
                if (i_tx_done) begin
                    state_d = ST_IDLE;
                    grant_d = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            last_q  <= IDX_W'(N_REQ - 1);
            grant_q <= '0;
            byte_q  <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            grant_q <= grant_d;
            byte_q  <= byte_d;
        end
    end

    assign o_tx_byte_rdy = (state_q == ST_ISSUE);
    assign o_req_ready   = {N_REQ{o_tx_byte_rdy}} & grant_q;
    assign o_grant       = grant_q;
    assign o_tx_byte     = byte_q;
    assign o_busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_tx_arb.sv
// tb/tb_uart_tx_arb.sv - scoreboard bench for uart_tx_arb with requester and serializer models
module tb_uart_tx_arb;

    localparam int N     = 4;
    localparam int FRAME = 6;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    req_valid = '0;
    logic [8*N-1:0]  req_byte = '0;
    logic [N-1:0]    req_last = '0;
    logic [N-1:0]    o_req_ready;
    logic [N-1:0]    o_grant;
    logic            o_tx_byte_rdy;
    logic [7:0]      o_tx_byte;
    logic            tx_busy = 1'b0;
    logic            tx_done = 1'b0;
    logic            o_busy;

    int total = 0;
    int bad   = 0;

    int unsigned exp_q[$];
    int unsigned rq[N][$];
    int          gap[N];

    logic ser_auto = 1'b0;
    int   ser_cnt  = 0;
    logic chk_seq  = 1'b0;
    int   n_issue  = 0;
    int   n_done   = 0;

    uart_tx_arb #(.N_REQ(N)) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_req_valid   (req_valid),
        .i_req_byte    (req_byte),
        .i_req_last    (req_last),
        .o_req_ready   (o_req_ready),
        .o_grant       (o_grant),
        .o_tx_byte_rdy (o_tx_byte_rdy),
        .o_tx_byte     (o_tx_byte),
        .i_tx_busy     (tx_busy),
        .i_tx_done     (tx_done),
        .o_busy        (o_busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int unsigned act, input int unsigned exp_v);
        total++;
        if (act !== exp_v) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp_v, $time);
        end
    endtask

    function automatic int unsigned itm(input int unsigned b, input int unsigned last, input int unsigned g);
        return (g << 16) | (last << 8) | (b & 8'hFF);
    endfunction

    // expected issue: byte in [7:0], one-hot grant in [15:8]
    task automatic expect_issue(input int unsigned b, input int unsigned g);
        exp_q.push_back((g << 8) | b);
    endtask

    task automatic push_req(input int k, input int unsigned it);
        rq[k].push_back(it);
    endtask

    // requester models: present head of queue, advance on ready, honour gap before next item
    initial begin
        int unsigned it;
        for (int k = 0; k < N; k++) gap[k] = 0;
        forever begin
            @(negedge clk);
            for (int k = 0; k < N; k++) begin
                if (o_req_ready[k] && rq[k].size() > 0) begin
                    it = rq[k].pop_front();
                    if (rq[k].size() > 0) begin
                        it = rq[k][0];
                        gap[k] = int'(it >> 16);
                    end
                end
                if (gap[k] > 0) begin
                    gap[k]--;
                    req_valid[k] = 1'b0;
                end else if (rq[k].size() > 0) begin
                    it = rq[k][0];
                    req_valid[k]        = 1'b1;
                    req_byte[8*k +: 8]  = it[7:0];
                    req_last[k]         = it[8];
                end else begin
                    req_valid[k] = 1'b0;
                end
            end
        end
    end

    // serializer model: busy for FRAME cycles after each start pulse, then one done pulse
    initial begin
        forever begin
            @(negedge clk);
            if (ser_auto) begin
                tx_done = 1'b0;
                if (o_tx_byte_rdy) begin
                    tx_busy = 1'b1;
                    ser_cnt = FRAME;
                end else if (ser_cnt > 0) begin
                    ser_cnt--;
                    if (ser_cnt == 0) begin
                        tx_busy = 1'b0;
                        tx_done = 1'b1;
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            if (tx_done) n_done++;
        end
    end

    // monitor: every start pulse is compared against the head of the scoreboard
    initial begin
        int unsigned e;
        logic prev_rdy;
        prev_rdy = 1'b0;
        forever begin
            @(negedge clk);
            if (o_tx_byte_rdy) begin
                check("rdy_single_cycle", prev_rdy, 0);
                if (exp_q.size() == 0) begin
                    check("unexpected_issue_byte", o_tx_byte, 9'h100);
                end else begin
                    e = exp_q.pop_front();
                    check("issue_byte", o_tx_byte, e & 8'hFF);
                    check("issue_grant", o_grant, (e >> 8) & 8'hFF);
                    check("issue_req_ready", o_req_ready, (e >> 8) & 8'hFF);
                end
                if (chk_seq) check("issue_after_done", n_issue, n_done);
                n_issue++;
            end
            prev_rdy = o_tx_byte_rdy;
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_rdy(input string name, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!o_tx_byte_rdy && n < 60);
        check({name, "_rdy_seen"}, o_tx_byte_rdy, 1);
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || o_busy) && n < 400) begin
            @(negedge clk);
            n++;
        end
        check({name, "_idle"}, o_busy, 0);
        check({name, "_sb_empty"}, exp_q.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int n;

        // reset state
        repeat (2) @(negedge clk);
        check("rst_req_ready", o_req_ready, 0);
        check("rst_grant", o_grant, 0);
        check("rst_tx_rdy", o_tx_byte_rdy, 0);
        check("rst_tx_byte", o_tx_byte, 0);
        check("rst_busy", o_busy, 0);
        rst_n = 1'b1;
        ser_auto = 1'b1;

        // single requester 2, byte 0xA5, start pulse one cycle after valid
        @(posedge clk);
        #1;
        expect_issue(8'hA5, 4'b0100);
        push_req(2, itm(8'hA5, 1, 0));
        wait_rdy("single", n);
        check("single_latency", n, 2);
        @(negedge clk);
        check("single_grant_held", o_grant, 4'b0100);
        check("single_ready_low", o_req_ready, 0);
        check("single_byte_held", o_tx_byte, 8'hA5);
        check("single_busy_wait", o_busy, 1);
        wait_drain("single");
        check("single_grant_clear", o_grant, 0);

        // four continuous requesters from reset: order 0,1,2,3,0
        do_reset();
        n_issue = 0;
        n_done  = 0;
        chk_seq = 1'b1;
        expect_issue(8'h10, 4'b0001);
        expect_issue(8'h11, 4'b0010);
        expect_issue(8'h12, 4'b0100);
        expect_issue(8'h13, 4'b1000);
        expect_issue(8'h10, 4'b0001);
        push_req(0, itm(8'h10, 1, 0));
        push_req(0, itm(8'h10, 1, 0));
        push_req(1, itm(8'h11, 1, 0));
        push_req(2, itm(8'h12, 1, 0));
        push_req(3, itm(8'h13, 1, 0));
        wait_drain("rr4");
        chk_seq = 1'b0;

        // serializer busy holds off issue until it falls
        ser_auto = 1'b0;
        tx_busy  = 1'b1;
        expect_issue(8'h5C, 4'b0010);
        push_req(1, itm(8'h5C, 1, 0));
        repeat (6) begin
            @(negedge clk);
            check("busy_hold_rdy", o_tx_byte_rdy, 0);
        end
        check("busy_hold_state", o_busy, 0);
        tx_busy = 1'b0;
        @(negedge clk);
        check("busy_release_issue", o_tx_byte_rdy, 1);
        tx_busy = 1'b1;
        repeat (3) @(negedge clk);
        tx_busy = 1'b0;
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
        wait_drain("busy");

        // done during ISSUE is ignored
        expect_issue(8'h77, 4'b0100);
        push_req(2, itm(8'h77, 1, 0));
        wait_rdy("early_done", n);
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
        check("early_done_still_busy", o_busy, 1);
        repeat (3) @(negedge clk);
        check("early_done_wait", o_busy, 1);
        check("early_done_grant", o_grant, 4'b0100);
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
        check("early_done_idle", o_busy, 0);

        // reset during WAIT, then busy serializer and requester 0 priority
        expect_issue(8'h22, 4'b0010);
        push_req(1, itm(8'h22, 1, 0));
        wait_rdy("midrst", n);
        tx_busy = 1'b1;
        @(negedge clk);
        check("midrst_in_wait", o_busy, 1);
        rst_n = 1'b0;
        #1;
        check("midrst_grant", o_grant, 0);
        check("midrst_busy", o_busy, 0);
        check("midrst_byte", o_tx_byte, 0);
        check("midrst_req_ready", o_req_ready, 0);
        check("midrst_tx_rdy", o_tx_byte_rdy, 0);
        expect_issue(8'h30, 4'b0001);
        expect_issue(8'h33, 4'b1000);
        push_req(3, itm(8'h33, 1, 0));
        push_req(0, itm(8'h30, 1, 0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("midrst_hold_rdy", o_tx_byte_rdy, 0);
        end
        tx_busy  = 1'b0;
        ser_auto = 1'b1;
        wait_drain("midrst");

        // packet lock: requester 1 sends 0x41 (last=0) then 0x42 after a long gap
        do_reset();
        expect_issue(8'h41, 4'b0010);
`ifdef UART_TX_ARB_PACKET_LOCK_EN
        expect_issue(8'h42, 4'b0010);
        expect_issue(8'h30, 4'b0001);
`else
        expect_issue(8'h30, 4'b0001);
        expect_issue(8'h42, 4'b0010);
`endif
        push_req(1, itm(8'h41, 0, 0));
        push_req(1, itm(8'h42, 1, 12));
        wait_rdy("lock", n);
        push_req(0, itm(8'h30, 1, 0));
        wait_drain("lock");

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
